uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver with an integrated receive FIFO. It generalises the fixed 8N1 serial link on the csoc_test rx pin to configurable data width, parity mode, baud divisor and buffer depth. Decoded words are buffered so the consumer can drain them at its own pace, using the same read-strobe style as csoc_uart_read. It also reports framing, parity and overrun errors.

Parameters:
CLKS_PER_BIT, 217, clk cycles per bit (25 MHz / 115200); legal range 4..65535
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_DEPTH, 16, FIFO entries; power of two, 2..256

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx  in  1  serial input; asynchronous, idles high
rd_en  in  1  pop strobe for the FIFO head
clr_err  in  1  clears all sticky error flags
data_o  out  DATA_BITS  FIFO head word (first-word fall-through)
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds FIFO_DEPTH entries
count  out  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: good word dropped because FIFO was full
busy  out  1  receiver is not in IDLE

Behaviour:
- Reset values: data_o=0, empty=1, full=0, count=0, all error flags=0, busy=0. The FSM goes to IDLE and the rx synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser (rxs). All FSM decisions use rxs.
- A down-counter bit_cnt is reloaded on every state transition.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE: when rxs==0, go to START and load bit_cnt=CLKS_PER_BIT/2-1.
- START: when bit_cnt==0, sample rxs.
  - rxs==0: go to DATA, load bit_cnt=CLKS_PER_BIT-1, clear the bit index.
  - rxs==1: treat as a glitch, return to IDLE with no flags set.
- DATA: at each bit_cnt==0, shift rxs into the shift register (LSB first) and reload the counter. After DATA_BITS samples, go to PAR if PARITY!=0, else go to STOP.
- PAR: at bit_cnt==0, sample the parity bit.
  - Odd parity: the XOR of data and parity bit must be 1.
  - Even parity: the XOR of data and parity bit must be 0.
  - A mismatch is latched internally as pending; go to STOP.
- STOP: at bit_cnt==0, sample the stop bit.
  - rxs==0: set frame_err, drop the word, go to BREAK.
  - rxs==1 with parity pending: set parity_err, drop the word, go to IDLE.
  - rxs==1 with no error: push the word, go to IDLE.
  - Frame error takes precedence over parity error; only frame_err is set.
- BREAK: wait until rxs==1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- busy=1 in every state except IDLE.
- Push timing: the push happens on the clock edge that samples the stop bit. empty deasserts and count increments on that same edge.
- Push is accepted if count<FIFO_DEPTH, or if rd_en=1 and empty=0 on the same cycle.
  - A full FIFO with a simultaneous pop accepts the push; count is unchanged.
  - A full FIFO with no pop drops the word and sets overrun. Existing FIFO contents are untouched.
- Pop: rd_en=1 with empty=0 advances the read pointer; data_o shows the next entry on the following cycle. rd_en while empty is ignored and does not underflow.
- Push and pop on the same cycle with empty=1: the push is accepted and the pop is ignored.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- full = (count==FIFO_DEPTH); empty = (count==0). Both are registered and consistent with count every cycle.
- Error flags are sticky until clr_err=1. If clr_err and a new error event occur on the same cycle, the flag ends up set (the set wins).
- rst asserted mid-frame aborts the frame immediately and empties the FIFO. After release, the receiver waits in IDLE for a fresh falling edge.

Test Plan:
1. CLKS_PER_BIT=16, 8N1, send 0xA5 -> empty falls 1 cycle after the stop-bit centre, data_o=0xA5, count=1; rd_en pulse -> empty=1, count=0.
2. PARITY=2, send 0x07 with parity bit 1 -> word stored, no flags. Send 0x07 with parity bit 0 -> parity_err=1, count unchanged. clr_err pulse -> parity_err=0.
3. Send 0x3C with the stop bit low, rx held low for 40 bit times, then released -> exactly one frame_err, busy stays high until rx returns high, FIFO unchanged.
4. FIFO_DEPTH=4, send 0x01..0x05 with no reads -> full=1 after the 4th word, 5th word dropped, overrun=1. Reads return 0x01..0x04 in order.
5. With FIFO full, pulse rd_en exactly on the 5th word's stop-sample edge -> word accepted, count stays 4, overrun=0. Reads return 0x02..0x05.
6. 1-cycle low glitch on rx in IDLE -> START rejects it, no push, no flags. Separately, assert rst during DATA of a frame -> all outputs at reset values; next clean frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width, parity, baud divisor) feeding a first-word fall-through FIFO.
// A word is pushed on the edge that samples its stop bit; rd_en pops the head. Errors are sticky until clr_err.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [CW-1:0]   FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0]   LAST_BIT    = IW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT   = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  state_t               state;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  logic tick;
  assign tick = (bit_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_pend <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (!tick) bit_cnt <= bit_cnt - 1'b1;
      case (state)
        IDLE: if (!rxs) begin
          state   <= START;
          bit_cnt <= HALF_RELOAD;
          busy    <= 1'b1;
        end
        START: if (tick) begin
          bit_cnt <= FULL_RELOAD;
          if (!rxs) begin
            state    <= DATA;
            bit_idx  <= '0;
            par_pend <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: if (tick) begin
          shreg   <= {rxs, shreg[DATA_BITS-1:1]};
          bit_cnt <= FULL_RELOAD;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state <= (PARITY != 0) ? PAR : STOP;
        end
        PAR: if (tick) begin
          // odd parity wants an overall XOR of 1, even wants 0
          par_pend <= ((^shreg) ^ rxs) != (PARITY == 1);
          state    <= STOP;
          bit_cnt  <= FULL_RELOAD;
        end
        STOP: if (tick) begin
          bit_cnt <= FULL_RELOAD;
          if (!rxs) begin
            state <= BREAK;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        BREAK: if (rxs) begin
          state   <= IDLE;
          bit_cnt <= FULL_RELOAD;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  logic stop_tick, frame_set, par_set, push_req, pop, push_ok, ovr_set;
  assign stop_tick = (state == STOP) && tick;
  assign frame_set = stop_tick && !rxs;
  assign par_set   = stop_tick && rxs && par_pend;
  assign push_req  = stop_tick && rxs && !par_pend;
  assign pop       = rd_en && !empty;
  // a full FIFO still takes the word when the head is leaving on the same edge
  assign push_ok   = push_req && (!full || pop);
  assign ovr_set   = push_req && full && !pop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNTW-1:0]      cnt_nxt;

  always_comb begin
    cnt_nxt = count + CNTW'(push_ok) - CNTW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == DEPTH_CNT);
    end
  end

  assign data_o = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (frame_err  & ~clr_err) | frame_set;
      parity_err <= (parity_err & ~clr_err) | par_set;
      overrun    <= (overrun    & ~clr_err) | ovr_set;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench: two receivers (8N1 and 8E1, 16 clocks/bit, 4-deep FIFO) with a queue scoreboard on the read side.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rd_en_a = 1'b0, clr_a = 1'b0;
  logic       rx_b = 1'b1, rd_en_b = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       empty_a, full_a, fe_a, pe_a, ov_a, busy_a;
  logic       empty_b, full_b, fe_b, pe_b, ov_b, busy_b;
  logic [2:0] count_a, count_b;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rd_en(rd_en_a), .clr_err(clr_a),
    .data_o(data_a), .empty(empty_a), .full(full_a), .count(count_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rd_en(rd_en_b), .clr_err(clr_b),
    .data_o(data_b), .empty(empty_b), .full(full_b), .count(count_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .busy(busy_b));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every accepted pop is compared with the oldest expected word.
  always @(negedge clk) begin
    if (!rst && rd_en_a && !empty_a) begin
      if (qa.size() == 0) chk("pop_a_unexpected", 1, 0);
      else chk("pop_a_data", int'(data_a), int'(qa.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && rd_en_b && !empty_b) begin
      if (qb.size() == 0) chk("pop_b_unexpected", 1, 0);
      else chk("pop_b_data", int'(data_b), int'(qb.pop_front()));
    end
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic bit_wait();
    repeat (16) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit use_par,
                      input bit pbit, input bit stopb);
    drive(sel, 1'b0);
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      bit_wait();
    end
    if (use_par) begin
      drive(sel, pbit);
      bit_wait();
    end
    drive(sel, stopb);
    bit_wait();
  endtask

  task automatic rd(input bit sel);
    @(posedge clk); #1;
    if (sel) rd_en_b = 1'b1; else rd_en_a = 1'b1;
    @(posedge clk); #1;
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  task automatic clr(input bit sel);
    @(posedge clk); #1;
    if (sel) clr_b = 1'b1; else clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_empty"}, empty_a, 1);
    chk({tag, "_full"},  full_a,  0);
    chk({tag, "_count"}, count_a, 0);
    chk({tag, "_data"},  data_a,  0);
    chk({tag, "_busy"},  busy_a,  0);
    chk({tag, "_flags"}, {fe_a, pe_a, ov_a}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_idle_a("rst_a");
    chk("rst_b_empty", empty_b, 1);
    chk("rst_b_flags", {fe_b, pe_b, ov_b, busy_b}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: stop sampled 155 clocks after the start edge (2 sync + 1 + 8 + 9*16)
    qa.push_back(8'hA5);
    @(negedge clk);
    fork
      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        lat = 0;
        while (empty_a && lat < 400) begin
          @(negedge clk);
          lat++;
        end
        chk("t1_latency", lat, 155);
      end
    join
    chk("t1_count", count_a, 1);
    chk("t1_data", data_a, 8'hA5);
    chk("t1_busy", busy_a, 0);
    rd(1'b0);
    @(negedge clk);
    chk("t1_empty_after_rd", empty_a, 1);
    chk("t1_count_after_rd", count_a, 0);

    // even parity on 0x07: parity bit 1 is correct, 0 is a mismatch
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    qb.push_back(8'h07);
    chk("t2_count", count_b, 1);
    chk("t2_clean_flags", {fe_b, pe_b}, 0);
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    chk("t2_parity_err", pe_b, 1);
    chk("t2_count_kept", count_b, 1);
    clr(1'b1);
    @(negedge clk);
    chk("t2_parity_cleared", pe_b, 0);
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    rx_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("t2_prec_frame", fe_b, 1);
    chk("t2_prec_parity", pe_b, 0);
    chk("t2_prec_count", count_b, 1);
    rd(1'b1);
    @(negedge clk);
    chk("t2_empty", empty_b, 1);

    // stop bit low then a long break: one frame error only
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t3_frame_err", fe_a, 1);
    chk("t3_busy_break", busy_a, 1);
    clr(1'b0);
    repeat (600) @(negedge clk);
    chk("t3_no_second_fe", fe_a, 0);
    chk("t3_busy_held", busy_a, 1);
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_busy_released", busy_a, 0);
    chk("t3_fifo_untouched", {empty_a, count_a}, 4'b1000);

    // overflow: 4 stored, 5th dropped
    for (int i = 1; i <= 4; i++) begin
      send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
      qa.push_back(8'(i));
    end
    chk("t4_full", full_a, 1);
    chk("t4_count", count_a, 4);
    chk("t4_no_overrun_yet", ov_a, 0);
    send(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
    chk("t4_overrun", ov_a, 1);
    chk("t4_count_kept", count_a, 4);
    for (int i = 0; i < 4; i++) rd(1'b0);
    @(negedge clk);
    chk("t4_drained", empty_a, 1);

    // full FIFO with a pop exactly on the stop-sample edge accepts the word
    clr(1'b0);
    @(negedge clk);
    chk("t5_overrun_cleared", ov_a, 0);
    for (int i = 1; i <= 4; i++) begin
      send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
      qa.push_back(8'(i));
    end
    chk("t5_full", full_a, 1);
    qa.push_back(8'h05);
    @(negedge clk);
    fork
      send(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rd_en_a = 1'b1;
        @(posedge clk);
        #1 rd_en_a = 1'b0;
      end
    join
    chk("t5_count", count_a, 4);
    chk("t5_full_kept", full_a, 1);
    chk("t5_no_overrun", ov_a, 0);
    for (int i = 0; i < 4; i++) rd(1'b0);
    @(negedge clk);
    chk("t5_drained", empty_a, 1);

    // one-clock glitch is rejected in START
    @(negedge clk);
    rx_a = 1'b0;
    @(negedge clk);
    rx_a = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_glitch_busy", busy_a, 1);
    repeat (20) @(negedge clk);
    chk_idle_a("t6_glitch");

    // reset mid-frame empties the FIFO and aborts the frame
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    qa.push_back(8'h11);
    chk("t6_pre_rst_count", count_a, 1);
    @(negedge clk);
    fork
      send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        qa.delete();
        @(negedge clk);
        chk_idle_a("t6_in_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    chk_idle_a("t6_after_rst");
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    qa.push_back(8'h5A);
    chk("t6_clean_count", count_a, 1);
    chk("t6_clean_data", data_a, 8'h5A);
    rd(1'b0);
    @(negedge clk);
    chk("t6_clean_empty", empty_a, 1);

    chk("sb_a_leftover", qa.size(), 0);
    chk("sb_b_leftover", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
